vga_timing: RTL and testbench

- Generates raster timing for the character display path: horizontal/vertical counters, sync pulses and blanking.
- Produces the newline/advance/line strobes consumed by the downstream pixeldata engine.
- Takes pixeldata's pixel output and emits blank-gated RGB, with sync and blank delayed to match the pixel pipeline.
- Default mode is 640x480@60 from a 25 MHz clk; lines are doubled, so the character engine sees 240 lines.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_if.sv | 24 ++
 rtl/vga_delay.sv | 31 +++
 rtl/vga_timing.sv | 114 +++++++++++
 tb/tb_vga_timing.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing constants and helpers for the character display path.
package vga_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int CNT_W         = 10;

   // act is the LSB so the delay line can tap it by index 0
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

   function automatic int total(input int vis, input int fr, input int sy, input int bk);
      return vis + fr + sy + bk;
   endfunction

   // sync comes first in the layout, so visible starts after sync + back porch
   function automatic int first_vis(input int sy, input int bk);
      return sy + bk;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Strobe and pixel bundle between vga_timing and the pixeldata engine / display.
interface vga_timing_if #(parameter int BPP = 2);

   logic             newline;
   logic             advance;
   logic [7:0]       line;
   logic             frame;
   logic [3*BPP-1:0] pixel;
   logic [3*BPP-1:0] rgb;
   logic             hsync;
   logic             vsync;
   logic             active;

   modport master (
      output newline, advance, line, frame, rgb, hsync, vsync, active,
      input  pixel
   );

   modport slave (
      input  newline, advance, line, frame, rgb, hsync, vsync, active,
      output pixel
   );

endinterface

// File: rtl/vga_delay.sv
// Synchronous-reset shift register; pre_o taps one bit of the value entering the last stage.
module vga_delay #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter int               TAP     = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic             pre_o,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH:0][WIDTH-1:0] pipe;

   assign pipe[0] = d_i;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stg
      logic [WIDTH-1:0] stg_q;
      always_ff @(posedge clk) begin
         if (reset) stg_q <= RST_VAL;
         else       stg_q <= pipe[i];
      end
      assign pipe[i+1] = stg_q;
   end

   assign pre_o = pipe[DEPTH-1][TAP];
   assign q_o   = pipe[DEPTH];

endmodule

// File: rtl/vga_timing.sv
// Raster counters, pixeldata strobes and pipeline-aligned sync/blank/rgb outputs.
module vga_timing
   import vga_pkg::*;
#(
   parameter int BPP        = 2,
   parameter int H_VISIBLE  = DEF_H_VISIBLE,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int V_VISIBLE  = DEF_V_VISIBLE,
   parameter int V_FRONT    = DEF_V_FRONT,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BACK     = DEF_V_BACK,
   parameter int PIPE_DELAY = 1
) (
   input  logic clk,
   input  logic reset,
   vga_timing_if.master vif
);

   localparam int H_TOTAL = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int H_ACT0  = first_vis(H_SYNC, H_BACK);
   localparam int V_ACT0  = first_vis(V_SYNC, V_BACK);

   localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT0_C = CNT_W'(H_ACT0);
   localparam logic [CNT_W-1:0] H_END_C  = CNT_W'(H_ACT0 + H_VISIBLE);
   localparam logic [CNT_W-1:0] V_ACT0_C = CNT_W'(V_ACT0);
   localparam logic [CNT_W-1:0] V_END_C  = CNT_W'(V_ACT0 + V_VISIBLE);

   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;
   logic [7:0]       line_q, line_d;
   logic [3*BPP-1:0] rgb_q, rgb_d;
   logic             h_vis, v_vis, v_vis_d;
   logic             newline, advance, frame;
   logic             act_nxt;
   sync_t            raw, dly;

   always_comb begin
      hcount_d = hcount_q + 1'b1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST_C) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + 1'b1;
      end
   end

   assign h_vis   = (hcount_q >= H_ACT0_C) && (hcount_q < H_END_C);
   assign v_vis   = (vcount_q >= V_ACT0_C) && (vcount_q < V_END_C);
   assign v_vis_d = (vcount_d >= V_ACT0_C) && (vcount_d < V_END_C);

   // line is loaded from the next-state counters so it is already valid alongside newline
   always_comb begin
      line_d = line_q;
      if ((hcount_d == '0) && v_vis_d)
         line_d = 8'((vcount_d - V_ACT0_C) >> 1);
   end

   // strobes are gated by reset so none leak out while the counters are being forced
   assign newline = ~reset && (hcount_q == '0) && v_vis;
   assign advance = ~reset && h_vis && v_vis;
   assign frame   = ~reset && (hcount_q == '0) && (vcount_q == '0);

   assign raw = '{hs: (hcount_q < H_SYNC_C), vs: (vcount_q < V_SYNC_C), act: advance};

   vga_delay #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DELAY),
      .TAP     (0),
      .RST_VAL (3'b000)
   ) u_dly (
      .clk   (clk),
      .reset (reset),
      .d_i   (raw),
      .pre_o (act_nxt),
      .q_o   (dly)
   );

   assign rgb_d = vif.pixel & {3*BPP{act_nxt}};

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount_q <= '0;
         vcount_q <= '0;
         line_q   <= '0;
         rgb_q    <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         line_q   <= line_d;
         rgb_q    <= rgb_d;
      end
   end

   always_ff @(posedge clk) begin
      assert (H_SYNC + H_BACK >= 8);
      assert ((PIPE_DELAY >= 1) && (PIPE_DELAY <= 4));
   end

   assign vif.newline = newline;
   assign vif.advance = advance;
   assign vif.frame   = frame;
   assign vif.line    = line_q;
   assign vif.rgb     = rgb_q;
   assign vif.hsync   = ~dly.hs;
   assign vif.vsync   = ~dly.vs;
   assign vif.active  = dly.act;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: a small-mode DUT at PIPE_DELAY 1 and 3 plus the default 640x480 mode.
module tb_vga_timing;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_timing_if #(.BPP(2)) s_if ();
   vga_timing_if #(.BPP(2)) t_if ();
   vga_timing_if #(.BPP(2)) d_if ();

   // small mode: HT = 6+4+16+4 = 30, VT = 2+3+8+2 = 15, frame = 450 clocks
   vga_timing #(.BPP(2), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
                .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(1))
      u_s (.clk(clk), .reset(reset), .vif(s_if));
   vga_timing #(.BPP(2), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
                .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(3))
      u_t (.clk(clk), .reset(reset), .vif(t_if));
   vga_timing #(.BPP(2)) u_d (.clk(clk), .reset(reset), .vif(d_if));

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d exp %0d", tag, got, exp);
      end
   endtask

   // {hsync,vsync,active,advance,newline,frame,rgb!=0,line}; idle/reset = 15'h6000
   function automatic int pk(logic hs, logic vs, logic act, logic adv, logic nl,
                             logic fr, logic [5:0] rgb, logic [7:0] ln);
      return int'({hs, vs, act, adv, nl, fr, |rgb, ln});
   endfunction

   task automatic chk_rst(input string tag);
      chk({tag, ".s"}, pk(s_if.hsync, s_if.vsync, s_if.active, s_if.advance, s_if.newline,
                          s_if.frame, s_if.rgb, s_if.line), 'h6000);
      chk({tag, ".t"}, pk(t_if.hsync, t_if.vsync, t_if.active, t_if.advance, t_if.newline,
                          t_if.frame, t_if.rgb, t_if.line), 'h6000);
      chk({tag, ".d"}, pk(d_if.hsync, d_if.vsync, d_if.active, d_if.advance, d_if.newline,
                          d_if.frame, d_if.rgb, d_if.line), 'h6000);
   endtask

   int frm_n, frm_t1, nl_n, nl_t0, adv_n, adv_t0, ovl_n, run_len, run_n, bad_run;
   int hs_low, vs_low, act_n, rgb_n, rgb_bad, line_idx, ln_blank, ln_nfb, ln_nf0;
   int s_fall[2], t_fall[2], s_fall_n, t_fall_n, s_rise, t_rise;
   int line_log[8];
   int d_hs_low, d_fall[2], d_fall_n, d_vs_low, d_nl_t0, d_ln0, d_adv, d_adv_t0;
   logic s_hs_p, t_hs_p, d_hs_p, s_act_p, t_act_p;

   // cycle c = 0 is the first cycle with reset low; samples are taken 1 time unit after the edge
   task automatic run(input int n);
      frm_n = 0; frm_t1 = -1; nl_n = 0; nl_t0 = -1; adv_n = 0; adv_t0 = -1; ovl_n = 0;
      run_len = 0; run_n = 0; bad_run = 0; hs_low = 0; vs_low = 0; act_n = 0; rgb_n = 0;
      rgb_bad = 0; line_idx = 0; ln_blank = -1; ln_nfb = -1; ln_nf0 = -1;
      s_fall = '{-1, -1}; t_fall = '{-1, -1}; s_fall_n = 0; t_fall_n = 0; s_rise = -1; t_rise = -1;
      line_log = '{default: -1};
      d_hs_low = 0; d_fall = '{-1, -1}; d_fall_n = 0; d_vs_low = 0; d_nl_t0 = -1; d_ln0 = -1;
      d_adv = 0; d_adv_t0 = -1;
      s_hs_p = 1'b1; t_hs_p = 1'b1; d_hs_p = 1'b1; s_act_p = 1'b0; t_act_p = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (c < 450) begin
            nl_n   += int'(s_if.newline);
            adv_n  += int'(s_if.advance);
            hs_low += int'(!s_if.hsync);
            vs_low += int'(!s_if.vsync);
            act_n  += int'(s_if.active);
            rgb_n  += int'(s_if.rgb != 6'd0);
         end
         if (s_if.frame) begin
            frm_n++;
            if (c > 0 && frm_t1 < 0) frm_t1 = c;
         end
         ovl_n += int'(s_if.newline && s_if.advance);
         if (s_if.newline) begin
            if (nl_t0 < 0) nl_t0 = c;
            if (line_idx < 8) begin line_log[line_idx] = int'(s_if.line); line_idx++; end
         end
         if (s_if.advance && adv_t0 < 0) adv_t0 = c;
         if (s_if.advance) run_len++;
         else if (run_len != 0) begin
            if (c < 450) begin run_n++; if (run_len != 16) bad_run++; end
            run_len = 0;
         end
         rgb_bad += int'(s_if.rgb != (s_if.active ? 6'h3f : 6'h00));
         rgb_bad += int'(t_if.rgb != (t_if.active ? 6'h3f : 6'h00));
         if (s_hs_p && !s_if.hsync && s_fall_n < 2) begin s_fall[s_fall_n] = c; s_fall_n++; end
         if (t_hs_p && !t_if.hsync && t_fall_n < 2) begin t_fall[t_fall_n] = c; t_fall_n++; end
         if (!s_act_p && s_if.active && s_rise < 0) s_rise = c;
         if (!t_act_p && t_if.active && t_rise < 0) t_rise = c;
         if (c == 430) ln_blank = int'(s_if.line);
         if (c == 500) ln_nfb = int'(s_if.line);
         if (c == 600) ln_nf0 = int'(s_if.line);
         if (c < 800) d_hs_low += int'(!d_if.hsync);
         if (d_hs_p && !d_if.hsync && d_fall_n < 2) begin d_fall[d_fall_n] = c; d_fall_n++; end
         d_vs_low += int'(!d_if.vsync);
         if (d_if.newline && d_nl_t0 < 0) begin d_nl_t0 = c; d_ln0 = int'(d_if.line); end
         if (c >= 28000 && c < 28800) d_adv += int'(d_if.advance);
         if (d_if.advance && d_adv_t0 < 0) d_adv_t0 = c;
         s_hs_p = s_if.hsync; t_hs_p = t_if.hsync; d_hs_p = d_if.hsync;
         s_act_p = s_if.active; t_act_p = t_if.active;
         @(posedge clk); #1;
      end
   endtask

   task automatic verify_small(input string tag, input int exp_frm);
      chk({tag, ".frm_n"},    frm_n,    exp_frm);
      chk({tag, ".frm_t1"},   frm_t1,   450);
      chk({tag, ".nl_n"},     nl_n,     8);
      chk({tag, ".nl_t0"},    nl_t0,    150);
      chk({tag, ".adv_n"},    adv_n,    128);
      chk({tag, ".adv_t0"},   adv_t0,   160);
      chk({tag, ".ovl"},      ovl_n,    0);
      chk({tag, ".run_n"},    run_n,    8);
      chk({tag, ".bad_run"},  bad_run,  0);
      chk({tag, ".s_fall0"},  s_fall[0], 1);
      chk({tag, ".s_fall1"},  s_fall[1], 31);
      chk({tag, ".t_fall0"},  t_fall[0], 3);
      chk({tag, ".t_fall1"},  t_fall[1], 33);
      chk({tag, ".hs_low"},   hs_low,   90);
      chk({tag, ".vs_low"},   vs_low,   60);
      chk({tag, ".s_rise"},   s_rise,   161);
      chk({tag, ".t_rise"},   t_rise,   163);
      chk({tag, ".act_n"},    act_n,    128);
      chk({tag, ".rgb_n"},    rgb_n,    128);
      chk({tag, ".rgb_bad"},  rgb_bad,  0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s.line%0d", tag, i), line_log[i], i / 2);
      chk({tag, ".ln_blank"}, ln_blank, 3);
      chk({tag, ".ln_nfb"},   ln_nfb,   3);
      chk({tag, ".ln_nf0"},   ln_nf0,   0);
   endtask

   initial begin
      s_if.pixel = '1;
      t_if.pixel = '1;
      d_if.pixel = '1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("rst0");
      reset = 1'b0;
      #1;
      chk("frame0.s", int'(s_if.frame), 1);
      chk("frame0.t", int'(t_if.frame), 1);
      chk("frame0.d", int'(d_if.frame), 1);

      run(29000);
      verify_small("r1", 65);
      chk("d.hs_low",   d_hs_low,  96);
      chk("d.fall0",    d_fall[0], 1);
      chk("d.fall1",    d_fall[1], 801);
      chk("d.vs_low",   d_vs_low,  1600);
      chk("d.nl_t0",    d_nl_t0,   28000);
      chk("d.ln0",      d_ln0,     0);
      chk("d.adv_line", d_adv,     640);
      chk("d.adv_t0",   d_adv_t0,  28144);

      // small mode now at v=6 h=20, default mode at v=36 h=200: both mid visible line
      chk("pre_rst.s.adv", int'(s_if.advance), 1);
      chk("pre_rst.d.adv", int'(d_if.advance), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_rst("rst1a");
      @(posedge clk); #1;
      chk_rst("rst1b");
      reset = 1'b0;
      #1;
      chk("frame1.s", int'(s_if.frame), 1);
      chk("frame1.d", int'(d_if.frame), 1);

      run(630);
      verify_small("r2", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
